// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-port single-port-RAM arbiter.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/ram_arbiter_sel.sv
// Combinational winner select between the two request ports.
// RAM_ARBITER_RR_EN selects round-robin on contention; otherwise port 0 has fixed priority.
module ram_arbiter_sel
    import ram_arbiter_pkg::*;
(
    input  logic [1:0] valids,
`ifdef RAM_ARBITER_RR_EN
    input  logic       last_grant,
`endif
    output logic [1:0] grant,
    output logic       grant_idx
);

    always_comb begin
        grant_idx = PORT0;
`ifdef RAM_ARBITER_RR_EN
        // On contention the port that did not win last time goes first.
        if (valids == 2'b11) begin
            grant_idx = ~last_grant;
        end else if (valids[1]) begin
            grant_idx = PORT1;
        end
`else
        if (!valids[0] && valids[1]) begin
            grant_idx = PORT1;
        end
`endif
        grant[0] = valids[0] && (grant_idx == PORT0);
        grant[1] = valids[1] && (grant_idx == PORT1);
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between two requesters; one transaction in flight, 3 cycles each.
// Define RAM_ARBITER_RR_EN for round-robin contention; default build is fixed priority to port 0.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter  int TAM_POSICIONES = 1024,
    parameter  int TAM_PALABRA    = 32,
    localparam int ADDR_W         = $clog2(TAM_POSICIONES)
) (
    input  logic                   CLK,
    input  logic                   RST,
    // Handshake: a request transfers on a rising edge where VALID and READY are both high;
    // VALID and its payload must stay stable until then. Responses have no backpressure.
    input  logic                   REQ0_VALID,
    input  logic                   REQ0_WR,
    input  logic [ADDR_W-1:0]      REQ0_ADDR,
    input  logic [TAM_PALABRA-1:0] REQ0_WDATA,
    output logic                   REQ0_READY,
    output logic                   RSP0_VALID,
    output logic [TAM_PALABRA-1:0] RSP0_RDATA,
    input  logic                   REQ1_VALID,
    input  logic                   REQ1_WR,
    input  logic [ADDR_W-1:0]      REQ1_ADDR,
    input  logic [TAM_PALABRA-1:0] REQ1_WDATA,
    output logic                   REQ1_READY,
    output logic                   RSP1_VALID,
    output logic [TAM_PALABRA-1:0] RSP1_RDATA,
    output logic                   RAM_CS,
    output logic                   RAM_WR,
    output logic                   RAM_OE,
    output logic [ADDR_W-1:0]      RAM_ADDR,
    output logic [TAM_PALABRA-1:0] RAM_DIN,
    input  logic [TAM_PALABRA-1:0] RAM_DOUT,
    output state_t                 DBG_STATE
);

    state_t                 state_q, state_d;
    logic                   owner_q, owner_d;
    op_t                    op_q, op_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [TAM_PALABRA-1:0] wdata_q, wdata_d;
    logic [TAM_PALABRA-1:0] rdata_q, rdata_d;
    logic                   last_grant_q, last_grant_d;

    logic [1:0]             valids;
    logic [1:0]             grant;
    logic                   grant_idx;
    logic                   accept;
    logic                   ram_cs, ram_wr, ram_oe;
    logic [ADDR_W-1:0]      ram_addr;
    logic [TAM_PALABRA-1:0] ram_din;

    assign valids = {REQ1_VALID, REQ0_VALID};

    ram_arbiter_sel u_sel (
        .valids     (valids),
`ifdef RAM_ARBITER_RR_EN
        .last_grant (last_grant_q),
`endif
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        last_grant_d = last_grant_q;
        accept       = 1'b0;
        ram_cs       = 1'b0;
        ram_wr       = 1'b0;
        ram_oe       = 1'b0;
        ram_addr     = '0;
        ram_din      = '0;
        case (state_q)
            IDLE: begin
                if (|valids) begin
                    accept       = 1'b1;
                    owner_d      = grant_idx;
                    op_d         = op_t'(grant_idx ? REQ1_WR : REQ0_WR);
                    addr_d       = grant_idx ? REQ1_ADDR : REQ0_ADDR;
                    wdata_d      = grant_idx ? REQ1_WDATA : REQ0_WDATA;
                    last_grant_d = grant_idx;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                ram_cs   = 1'b1;
                ram_addr = addr_q;
                if (op_q == OP_WR) begin
                    ram_wr  = 1'b1;
                    ram_din = wdata_q;
                end else begin
                    ram_oe  = 1'b1;
                    rdata_d = RAM_DOUT;
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            owner_q      <= PORT0;
            op_q         <= OP_RD;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            last_grant_q <= PORT1;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Strobes are masked by RST so an access cut short by reset never touches the RAM.
    assign RAM_CS     = ram_cs & ~RST;
    assign RAM_WR     = ram_wr & ~RST;
    assign RAM_OE     = ram_oe & ~RST;
    assign RAM_ADDR   = ram_addr;
    assign RAM_DIN    = ram_din;

    assign REQ0_READY = accept & grant[0] & ~RST;
    assign REQ1_READY = accept & grant[1] & ~RST;

    assign RSP0_VALID = (state_q == RESP) && (owner_q == PORT0);
    assign RSP1_VALID = (state_q == RESP) && (owner_q == PORT1);
    assign RSP0_RDATA = (RSP0_VALID && op_q == OP_RD) ? rdata_q : '0;
    assign RSP1_RDATA = (RSP1_VALID && op_q == OP_RD) ? rdata_q : '0;

    assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus random traffic against a
// transaction-timing reference model (accept at t, RAM access at t+1, response at t+2).
`timescale 1ns/1ps
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;
`ifdef RAM_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT hookup ----------------
    logic [1:0]    req_valid = 2'b00;
    logic [1:0]    req_wr    = 2'b00;
    logic [AW-1:0] req_addr  [2];
    logic [DW-1:0] req_wdata [2];
    logic          ready0, ready1, rsp_v0, rsp_v1;
    logic [DW-1:0] rsp_d0, rsp_d1;
    logic [1:0]    rdy;
    logic          ram_cs, ram_wr, ram_oe;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;
    state_t        dbg_state;

    assign rdy = {ready1, ready0};

    ram_arbiter #(.TAM_POSICIONES(DEPTH), .TAM_PALABRA(DW)) dut (
        .CLK(clk), .RST(rst),
        .REQ0_VALID(req_valid[0]), .REQ0_WR(req_wr[0]), .REQ0_ADDR(req_addr[0]),
        .REQ0_WDATA(req_wdata[0]), .REQ0_READY(ready0), .RSP0_VALID(rsp_v0), .RSP0_RDATA(rsp_d0),
        .REQ1_VALID(req_valid[1]), .REQ1_WR(req_wr[1]), .REQ1_ADDR(req_addr[1]),
        .REQ1_WDATA(req_wdata[1]), .REQ1_READY(ready1), .RSP1_VALID(rsp_v1), .RSP1_RDATA(rsp_d1),
        .RAM_CS(ram_cs), .RAM_WR(ram_wr), .RAM_OE(ram_oe), .RAM_ADDR(ram_addr),
        .RAM_DIN(ram_din), .RAM_DOUT(ram_dout), .DBG_STATE(dbg_state)
    );

    // ---------------- RAM device model ----------------
    function automatic logic [DW-1:0] init_val(input int i);
        return (i == DEPTH - 1) ? 32'hA5A5_A5A5 : (32'hA5A5_0000 | DW'(i));
    endfunction

    logic [DW-1:0] ram_mem [DEPTH];
    bit            loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] <= init_val(i);
            loaded <= 1'b1;
        end else if (ram_cs && ram_wr) begin
            ram_mem[ram_addr] <= ram_din;
        end
    end
    // Undriven bus shows as garbage so a stray sample is visible.
    assign ram_dout = (ram_cs && ram_oe && !ram_wr) ? ram_mem[ram_addr] : 32'h0BAD_F00D;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    bit            mon_en    = 1'b0;
    int unsigned   cyc       = 0;
    int unsigned   next_free = 0;
    int unsigned   t_acc     = 0;
    bit            txn_live  = 1'b0;
    bit            last_g    = 1'b1;
    bit            t_port, t_wr, win;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata;
    logic [1:0]    e_rdy, e_rsp;
    logic          e_cs, e_wr, e_oe;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din, e_rd0, e_rd1;
    state_t        e_state;

    always @(negedge clk) begin
        if (mon_en) begin
            e_rdy = 2'b00; e_rsp = 2'b00; e_cs = 1'b0; e_wr = 1'b0; e_oe = 1'b0;
            e_addr = '0; e_din = '0; e_rd0 = '0; e_rd1 = '0; e_state = IDLE;
            if (rst) begin
                check("rst_ready", rdy, 2'b00);
                check("rst_ram_ctl", {ram_cs, ram_wr, ram_oe}, 3'b000);
                txn_live  = 1'b0;
                next_free = cyc + 1;
                last_g    = 1'b1;
                exp_q.delete();
            end else begin
                if (txn_live && cyc == t_acc + 1) begin
                    e_state = ACCESS; e_cs = 1'b1; e_wr = t_wr; e_oe = !t_wr; e_addr = t_addr;
                    if (t_wr) begin
                        e_din = t_wdata;
                        model_mem[t_addr] = t_wdata;
                        exp_q.push_back('0);
                    end else begin
                        exp_q.push_back(model_mem[t_addr]);
                    end
                end else if (txn_live && cyc == t_acc + 2) begin
                    e_state = RESP;
                    e_rsp[t_port] = 1'b1;
                    if (t_port) e_rd1 = exp_q.pop_front();
                    else        e_rd0 = exp_q.pop_front();
                    txn_live = 1'b0;
                end
                if (cyc >= next_free && req_valid != 2'b00) begin
                    win = (req_valid == 2'b11) ? (RR ? !last_g : 1'b0) : req_valid[1];
                    e_rdy[win] = 1'b1;
                    t_port = win; t_wr = req_wr[win]; t_addr = req_addr[win]; t_wdata = req_wdata[win];
                    t_acc = cyc; txn_live = 1'b1; next_free = cyc + 3; last_g = win;
                end
                check("ready", rdy, e_rdy);
                check("ram_cs", ram_cs, e_cs);
                check("ram_wr", ram_wr, e_wr);
                check("ram_oe", ram_oe, e_oe);
                check("ram_addr", ram_addr, e_addr);
                check("ram_din", ram_din, e_din);
                check("rsp0_valid", rsp_v0, e_rsp[0]);
                check("rsp0_rdata", rsp_d0, e_rd0);
                check("rsp1_valid", rsp_v1, e_rsp[1]);
                check("rsp1_rdata", rsp_d1, e_rd1);
                check("state", dbg_state, e_state);
            end
            cyc++;
        end
    end

    // ---------------- driver tasks (called just after a rising edge) ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int p, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit got = 1'b0;
        req_wr[p]    = wr;
        req_addr[p]  = a;
        req_wdata[p] = wr ? d : '0;
        req_valid[p] = 1'b1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            got = rdy[p];
            @(posedge clk);
            #1;
        end
        check($sformatf("p%0d_accept", p), got, 1'b1);
        if (!got) req_valid[p] = 1'b0;
    endtask

    task automatic release_port(input int p);
        req_valid[p] = 1'b0;
    endtask

    task automatic rand_port(input int p, input int n);
        for (int k = 0; k < n; k++) begin
            int            sel;
            logic [AW-1:0] a;
            sel = $urandom_range(0, 5);
            if (sel == 0)      a = '0;
            else if (sel == 1) a = AW'(DEPTH - 1);
            else if (sel == 2) a = AW'($urandom_range(0, DEPTH - 1));
            else               a = AW'($urandom_range(0, 15));
            send(p, 1'($urandom_range(0, 1)), a, $urandom);
            release_port(p);
            wait_cycles($urandom_range(0, 6));
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = init_val(i);
        for (int p = 0; p < 2; p++) begin
            req_addr[p]  = '0;
            req_wdata[p] = '0;
        end
        mon_en = 1'b1;

        // reset for several edges; monitor confirms strobes low and idle outputs afterwards
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_cycles(2);

        // basic write then read-back on port 0
        send(0, 1'b1, 10'h005, 32'hDEAD_BEEF);
        send(0, 1'b0, 10'h005, '0);
        release_port(0);
        wait_cycles(3);

        // both ports hold reads together
        req_wr[0] = 1'b0; req_addr[0] = 10'h005;
        req_wr[1] = 1'b0; req_addr[1] = 10'h3FF;
        req_valid = 2'b11;
        wait_cycles(12);
        req_valid = 2'b00;
        wait_cycles(4);

        // port 1 write aborted by reset during its RAM access cycle
        send(1, 1'b1, 10'h3FF, 32'h1234_5678);
        rst = 1'b1;
        release_port(1);
        @(posedge clk);
        #1 rst = 1'b0;
        send(1, 1'b0, 10'h3FF, '0);
        release_port(1);
        wait_cycles(3);

        // port 1 back-to-back writes with VALID held, then read-back
        for (int i = 0; i < 4; i++) send(1, 1'b1, AW'(i), $urandom);
        for (int i = 0; i < 4; i++) send(1, 1'b0, AW'(i), '0);
        release_port(1);
        wait_cycles(2);

        // top and bottom address do not alias
        send(0, 1'b1, 10'h3FF, 32'hCAFE_0FFF);
        send(0, 1'b1, 10'h000, 32'h0000_1111);
        send(0, 1'b0, 10'h3FF, '0);
        send(0, 1'b0, 10'h000, '0);
        release_port(0);
        wait_cycles(3);

        // random concurrent traffic
        fork
            rand_port(0, 40);
            rand_port(1, 40);
        join
        wait_cycles(6);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
